// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types for the L1 memory arbiter: the LC-3b word/line types plus the
// arbiter state and owner encodings, and the tie-break helper.
package l1_mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] l1_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // Winner when both caches request in the same IDLE cycle. Round-robin hands
  // the port to whoever did not own it last; fixed priority always favours D.
  function automatic arb_owner_t tie_winner(input arb_owner_t last_owner,
                                            input bit         rr_enable);
    arb_owner_t win;
    win = OWNER_D;
    if (rr_enable && (last_owner == OWNER_D)) begin
      win = OWNER_I;
    end
    return win;
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// Bundle of the three handshakes around the arbiter: I-cache side, D-cache
// side and the shared downstream (write buffer source) port.
interface l1_mem_arbiter_if;
  import l1_mem_arbiter_pkg::*;

  // I-cache side
  logic         icache_read;
  lc3b_word     icache_addr;
  l1_cache_line icache_rdata;
  logic         icache_resp;

  // D-cache side
  logic         dcache_read;
  logic         dcache_write;
  lc3b_word     dcache_addr;
  l1_cache_line dcache_wdata;
  l1_cache_line dcache_rdata;
  logic         dcache_resp;

  // Shared downstream port
  logic         arb_read;
  logic         arb_write;
  lc3b_word     arb_addr;
  l1_cache_line arb_wdata;
  l1_cache_line arb_rdata;
  logic         arb_resp;

  // Arbiter view: it masters the downstream port and serves both caches.
  modport master (
    input  icache_read, icache_addr,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output arb_read, arb_write, arb_addr, arb_wdata,
    input  arb_rdata, arb_resp
  );

  // Environment view: caches and the downstream buffer.
  modport slave (
    output icache_read, icache_addr,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_addr, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  arb_read, arb_write, arb_addr, arb_wdata,
    output arb_rdata, arb_resp
  );

endinterface

// File: rtl/l1_mem_arbiter_sat_counter.sv
// Saturating up-counter used for per-requester grant statistics. Holds at
// all-ones instead of wrapping so a long run never reads as "few grants".
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: bump on enable unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Two-way arbiter sharing the write buffer's source port between the L1
// I-cache and D-cache. One owner at a time, grant held until the downstream
// response; at least one IDLE cycle between grants.
//
// state   | meaning
// IDLE    | no downstream request driven, arbitrating
// SERVE_I | I-cache owns the downstream port
// SERVE_D | D-cache owns the downstream port
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  l1_mem_arbiter_if.master     bus,
  output logic [CNT_WIDTH-1:0] i_grant_count,
  output logic [CNT_WIDTH-1:0] d_grant_count
);

  arb_state_t state_q, state_d;
  arb_owner_t last_q, last_d;
  logic       req_i;
  logic       req_d;
  logic       grant_i;
  logic       grant_d;

  assign req_i = bus.icache_read;
  assign req_d = bus.dcache_read | bus.dcache_write;

  // Next-state and last-owner selection. Requests are only sampled in IDLE,
  // which is what gives the one-cycle arbitration latency and the IDLE gap.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          if (tie_winner(last_q, RR_ENABLE) == OWNER_D) begin
            state_d = SERVE_D;
          end else begin
            state_d = SERVE_I;
          end
        end else if (req_i) begin
          state_d = SERVE_I;
        end else if (req_d) begin
          state_d = SERVE_D;
        end
      end
      // A requester dropping early abandons the transaction rather than
      // leaving the port owned by nobody.
      SERVE_I: begin
        if (bus.arb_resp || !req_i) begin
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.arb_resp || !req_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == SERVE_I && state_q == IDLE) begin
      last_d = OWNER_I;
    end else if (state_d == SERVE_D && state_q == IDLE) begin
      last_d = OWNER_D;
    end
  end

  // State and last-owner registers; reset leaves last owner at I so the
  // first tie goes to D.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= OWNER_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign grant_i = (state_q == IDLE) && (state_d == SERVE_I);
  assign grant_d = (state_q == IDLE) && (state_d == SERVE_D);

  // Downstream steering and response routing. Controls follow the owner
  // combinationally so an early drop deasserts the port in the same cycle.
  // Write data always comes from the D-cache; it is ignored on I-cache reads.
  always_comb begin
    bus.arb_read    = 1'b0;
    bus.arb_write   = 1'b0;
    bus.arb_addr    = '0;
    bus.arb_wdata   = bus.dcache_wdata;
    bus.icache_resp = 1'b0;
    bus.dcache_resp = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        bus.arb_read    = bus.icache_read;
        bus.arb_addr    = bus.icache_addr;
        bus.icache_resp = bus.arb_resp;
      end
      SERVE_D: begin
        bus.arb_read    = bus.dcache_read;
        bus.arb_write   = bus.dcache_write;
        bus.arb_addr    = bus.dcache_addr;
        bus.dcache_resp = bus.arb_resp;
      end
      default: begin
        bus.arb_read = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; only the resp strobes qualify it.
  assign bus.icache_rdata = bus.arb_rdata;
  assign bus.dcache_rdata = bus.arb_rdata;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_i_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (grant_i),
    .count_o (i_grant_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (grant_d),
    .count_o (d_grant_count)
  );

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: a round-robin 16-bit-counter instance and a
// fixed-priority 2-bit-counter instance, one active at a time. Expected
// grants are queued as requests are driven and checked when they appear.
`timescale 1ns/1ps
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  typedef struct {
    arb_owner_t   own;
    logic         wr;
    lc3b_word     addr;
    l1_cache_line wdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  l1_mem_arbiter_if ia ();
  l1_mem_arbiter_if ib ();
  logic [15:0] a_icnt, a_dcnt;
  logic [1:0]  b_icnt, b_dcnt;

  l1_mem_arbiter #(.RR_ENABLE(1'b1), .CNT_WIDTH(16)) u_rr (
    .clk(clk), .reset(reset), .bus(ia.master),
    .i_grant_count(a_icnt), .d_grant_count(a_dcnt));

  l1_mem_arbiter #(.RR_ENABLE(1'b0), .CNT_WIDTH(2)) u_fp (
    .clk(clk), .reset(reset), .bus(ib.master),
    .i_grant_count(b_icnt), .d_grant_count(b_dcnt));

  // stimulus, fanned to the selected instance only
  logic         sel = 1'b0;
  logic         drv_iread = 1'b0, drv_dread = 1'b0, drv_dwrite = 1'b0;
  lc3b_word     drv_iaddr = '0, drv_daddr = '0;
  l1_cache_line drv_wdata = '0;
  logic         mem_resp = 1'b0;
  l1_cache_line mem_rdata = '0;

  assign ia.icache_read  = drv_iread & ~sel;
  assign ia.dcache_read  = drv_dread & ~sel;
  assign ia.dcache_write = drv_dwrite & ~sel;
  assign ia.icache_addr  = drv_iaddr;
  assign ia.dcache_addr  = drv_daddr;
  assign ia.dcache_wdata = drv_wdata;
  assign ia.arb_resp     = mem_resp & ~sel;
  assign ia.arb_rdata    = mem_rdata;
  assign ib.icache_read  = drv_iread & sel;
  assign ib.dcache_read  = drv_dread & sel;
  assign ib.dcache_write = drv_dwrite & sel;
  assign ib.icache_addr  = drv_iaddr;
  assign ib.dcache_addr  = drv_daddr;
  assign ib.dcache_wdata = drv_wdata;
  assign ib.arb_resp     = mem_resp & sel;
  assign ib.arb_rdata    = mem_rdata;

  logic         m_read, m_write, m_iresp, m_dresp;
  lc3b_word     m_addr;
  l1_cache_line m_wdata, m_irdata, m_drdata;
  logic [15:0]  m_icnt, m_dcnt;
  assign m_read   = sel ? ib.arb_read     : ia.arb_read;
  assign m_write  = sel ? ib.arb_write    : ia.arb_write;
  assign m_addr   = sel ? ib.arb_addr     : ia.arb_addr;
  assign m_wdata  = sel ? ib.arb_wdata    : ia.arb_wdata;
  assign m_iresp  = sel ? ib.icache_resp  : ia.icache_resp;
  assign m_dresp  = sel ? ib.dcache_resp  : ia.dcache_resp;
  assign m_irdata = sel ? ib.icache_rdata : ia.icache_rdata;
  assign m_drdata = sel ? ib.dcache_rdata : ia.dcache_rdata;
  assign m_icnt   = sel ? {14'd0, b_icnt} : a_icnt;
  assign m_dcnt   = sel ? {14'd0, b_dcnt} : a_dcnt;

  exp_t sb_q[$];

  function automatic l1_cache_line exp_line(input lc3b_word a);
    return {16{8'hA5}} ^ {8{a}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // downstream buffer model: responds in the 4th cycle a request is visible
  int mem_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (reset || mem_resp) begin
      mem_resp = 1'b0;
      mem_cnt  = 0;
    end else if (m_read | m_write) begin
      mem_cnt++;
      if (mem_cnt == 4) begin
        mem_resp  = 1'b1;
        mem_rdata = exp_line(m_addr);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // grant / response monitor
  logic prev_act = 1'b0, prev_resp = 1'b0;
  int   last_resp_cyc = -1, last_gap = 0, viol = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      prev_act  = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if ((m_read | m_write) && !prev_act) begin
        if (last_resp_cyc >= 0) begin
          last_gap = cyc - last_resp_cyc;
          chk("idle_gap", last_gap >= 2, 1);
        end
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          chk("grant_addr", m_addr, cur.addr);
          chk("grant_write", m_write, cur.wr);
          chk("grant_read", m_read, !cur.wr);
          if (cur.wr) chk("grant_wdata", m_wdata, cur.wdata);
        end
      end
      if (mem_resp) begin
        chk("iresp", m_iresp, cur.own == OWNER_I);
        chk("dresp", m_dresp, cur.own == OWNER_D);
        chk("rdata", (cur.own == OWNER_I) ? m_irdata : m_drdata, exp_line(cur.addr));
        last_resp_cyc = cyc;
      end
      if (prev_act && !(m_read | m_write) && !prev_resp) viol++;
      prev_act  = m_read | m_write;
      prev_resp = mem_resp;
    end
  end

  task automatic push(input arb_owner_t o, input logic wr, input lc3b_word a, input l1_cache_line d);
    exp_t e;
    e.own = o; e.wr = wr; e.addr = a; e.wdata = d;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk); #2;
    reset = 1'b1; sel = s;
    drv_iread = 1'b0; drv_dread = 1'b0; drv_dwrite = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_resp(input bit is_i);
    bit ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = is_i ? m_iresp : m_dresp;
    end
    chk(is_i ? "i_resp_seen" : "d_resp_seen", ok, 1);
  endtask

  task automatic i_txn(input lc3b_word a);
    drv_iaddr = a; drv_iread = 1'b1;
    wait_resp(1'b1);
    @(posedge clk); #2; drv_iread = 1'b0;
  endtask

  task automatic d_txn(input logic wr, input lc3b_word a, input l1_cache_line d);
    drv_daddr = a; drv_wdata = d;
    if (wr) drv_dwrite = 1'b1; else drv_dread = 1'b1;
    wait_resp(1'b0);
    @(posedge clk); #2; drv_dwrite = 1'b0; drv_dread = 1'b0;
  endtask

  initial begin
    int c0;
    // --- reset state and single I-cache fill (round-robin instance)
    do_reset(1'b0);
    @(negedge clk);
    chk("rst_arb_read", m_read, 0);
    chk("rst_arb_write", m_write, 0);
    chk("rst_iresp", m_iresp, 0);
    chk("rst_dresp", m_dresp, 0);
    chk("rst_icnt", m_icnt, 0);
    chk("rst_dcnt", m_dcnt, 0);
    @(posedge clk); #2;
    c0 = cyc;
    push(OWNER_I, 1'b0, 16'h0040, '0);
    drv_iaddr = 16'h0040; drv_iread = 1'b1;
    @(negedge clk); chk("lat_cycle0_read", m_read, 0);
    @(negedge clk); chk("lat_cycle1_read", m_read, 1);
    wait_resp(1'b1);
    chk("t1_resp_cycle", cyc - c0, 4);
    chk("t1_irdata", m_irdata, {8{16'hA5E5}});
    chk("t1_dresp", m_dresp, 0);
    @(posedge clk); #2; drv_iread = 1'b0;
    chk("t1_icnt", m_icnt, 1);

    // --- simultaneous requests after reset: D first, then I
    do_reset(1'b0);
    push(OWNER_D, 1'b1, 16'h0200, {8{16'h1234}});
    push(OWNER_I, 1'b0, 16'h0100, '0);
    fork
      i_txn(16'h0100);
      d_txn(1'b1, 16'h0200, {8{16'h1234}});
    join
    chk("rr_gap", last_gap, 2);
    chk("rr_icnt", m_icnt, 1);
    chk("rr_dcnt", m_dcnt, 1);
    // D alone, then a tie must go to I
    push(OWNER_D, 1'b0, 16'h0210, '0);
    d_txn(1'b0, 16'h0210, '0);
    push(OWNER_I, 1'b0, 16'h0110, '0);
    push(OWNER_D, 1'b1, 16'h0220, {8{16'h5678}});
    fork
      i_txn(16'h0110);
      d_txn(1'b1, 16'h0220, {8{16'h5678}});
    join
    chk("rr2_icnt", m_icnt, 2);
    chk("rr2_dcnt", m_dcnt, 3);

    // --- reset in the middle of a D-cache writeback
    do_reset(1'b0);
    @(posedge clk); #2;
    push(OWNER_D, 1'b1, 16'h0300, {8{16'hCAFE}});
    drv_daddr = 16'h0300; drv_wdata = {8{16'hCAFE}}; drv_dwrite = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk); chk("mid_rst_still_serving", m_write, 1);
    @(posedge clk); #2;
    reset = 1'b0; drv_dwrite = 1'b0;
    @(negedge clk);
    chk("post_rst_write", m_write, 0);
    chk("post_rst_dcnt", m_dcnt, 0);
    chk("post_rst_icnt", m_icnt, 0);
    push(OWNER_I, 1'b0, 16'h0444, '0);
    @(posedge clk); #2;
    i_txn(16'h0444);
    chk("post_rst_icnt1", m_icnt, 1);

    // --- D-cache drops its read before resp
    @(posedge clk); #2;
    push(OWNER_D, 1'b0, 16'h0500, '0);
    push(OWNER_D, 1'b0, 16'h0500, '0);
    drv_daddr = 16'h0500; drv_dread = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    drv_dread = 1'b0;
    @(negedge clk); chk("drop_same_cycle", m_read, 0);
    @(posedge clk); #2;
    drv_dread = 1'b1;
    @(negedge clk); chk("drop_idle_next", m_read, 0);
    wait_resp(1'b0);
    @(posedge clk); #2; drv_dread = 1'b0;
    chk("proto_violation", viol, 1);
    chk("drop_dcnt", m_dcnt, 2);

    // --- fixed priority, 2-bit counters: both requesting continuously
    do_reset(1'b1);
    @(negedge clk);
    chk("fp_rst_icnt", m_icnt, 0);
    chk("fp_rst_dcnt", m_dcnt, 0);
    @(posedge clk); #2;
    for (int n = 0; n < 5; n++) push(OWNER_D, 1'b1, 16'h0600, {8{16'hBEEF}});
    drv_iaddr = 16'h0700; drv_iread = 1'b1;
    drv_daddr = 16'h0600; drv_wdata = {8{16'hBEEF}}; drv_dwrite = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      wait_resp(1'b0);
      chk("fp_dcnt", m_dcnt, (n < 3) ? n : 3);
      chk("fp_icnt", m_icnt, 0);
    end
    @(posedge clk); #2;
    drv_iread = 1'b0; drv_dwrite = 1'b0;
    // I-cache alone, counter saturates at 3
    for (int n = 1; n <= 5; n++) begin
      push(OWNER_I, 1'b0, 16'h0710 + 16'(n), '0);
      i_txn(16'h0710 + 16'(n));
      chk("sat_icnt", m_icnt, (n < 3) ? n : 3);
    end
    chk("sat_dcnt_hold", m_dcnt, 3);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single downstream memory port (the eviction write buffer's source_* interface) between the L1 instruction cache and the L1 data cache.
- Grants one requester at a time and holds the grant until the downstream response.
- Steers address, data and control onto the shared port, and routes the response back to the granted requester only.
- Round-robin or fixed-priority arbitration; saturating per-requester grant counters for performance monitoring.

Parameters:
- RR_ENABLE, 1, 1 = round-robin on tie; 0 = fixed priority, D-cache always wins a tie.
- CNT_WIDTH, 16, width of each grant counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- icache_read  in  1  I-cache line-fill request
- icache_addr  in  lc3b_word  I-cache line address
- icache_rdata  out  l1_cache_line  line returned to I-cache
- icache_resp  out  1  I-cache transaction complete
- dcache_read  in  1  D-cache line-fill request
- dcache_write  in  1  D-cache writeback request
- dcache_addr  in  lc3b_word  D-cache line address
- dcache_wdata  in  l1_cache_line  D-cache writeback data
- dcache_rdata  out  l1_cache_line  line returned to D-cache
- dcache_resp  out  1  D-cache transaction complete
- arb_read  out  1  to buffer source_read
- arb_write  out  1  to buffer source_write
- arb_addr  out  lc3b_word  to buffer source_addr
- arb_wdata  out  l1_cache_line  to buffer source_data
- arb_rdata  in  l1_cache_line  from buffer mem_data
- arb_resp  in  1  from buffer out_resp
- i_grant_count  out  CNT_WIDTH  I-cache grants since reset, saturating
- d_grant_count  out  CNT_WIDTH  D-cache grants since reset, saturating

Behaviour:
- Reset values:
  - state = IDLE; last_grant = I, so D wins the first tie.
  - Counters = 0.
  - All arb_* controls and both *_resp = 0.
- States:
  - IDLE: no downstream request driven.
  - SERVE_I: I-cache owns the port.
  - SERVE_D: D-cache owns the port.
- IDLE, requests present (reqI = icache_read; reqD = dcache_read | dcache_write):
  - Only reqI -> SERVE_I next edge.
  - Only reqD -> SERVE_D next edge.
  - Both, RR_ENABLE=1 -> grant the requester not equal to last_grant.
  - Both, RR_ENABLE=0 -> SERVE_D.
  - On entering a SERVE state: update last_grant; increment that requester's counter, holding at all-ones.
- Arbitration latency: a request is never forwarded in the cycle it first appears; the downstream request starts one cycle after the request.
- SERVE_x outputs:
  - arb_read, arb_write, arb_addr, arb_wdata are combinational copies of requester x's signals.
  - In SERVE_I, arb_write = 0 and arb_wdata = dcache_wdata (don't-care).
  - x_resp = arb_resp, same cycle; the other requester's resp = 0.
- SERVE_x exit:
  - arb_resp = 1 -> IDLE next edge.
  - Requester x drops its request before arb_resp -> IDLE next edge; arb_* deassert immediately. This is a protocol violation, flagged by a bench assertion.
- IDLE spacing: at least one IDLE cycle separates grants, so a requester's still-high request in its resp cycle is never re-granted.
- Read data routing: icache_rdata and dcache_rdata are both driven from arb_rdata at all times; only resp qualifies them.
- dcache_read and dcache_write both high: forward both unchanged; the buffer gives read priority. Bench treats this as illegal.
- Address or data changing during SERVE_x is passed through; requesters hold stable until resp.
- reset high in any state: IDLE on the next edge; outputs return to reset values. An in-flight downstream transaction is abandoned, and the buffer must be reset in the same cycle.
- A counter at all-ones does not wrap.

Decomposition:
- lc3b_types already provides lc3b_word and l1_cache_line.
- Add arb_state_t (IDLE, SERVE_I, SERVE_D) and arb_owner_t (OWNER_I, OWNER_D) to lc3b_types.
- One natural sub-module: sat_counter, parameterised width, with increment enable and synchronous reset; instantiated twice.
- Arbitration FSM and output mux stay in the top module.

Test Plan:
- Reset, then reqI alone, addr 16'h0040; downstream resp on cycle 4 with rdata 128'hA5... -> arb_read=1 from cycle 1; icache_resp=1 only on cycle 4 with icache_rdata=128'hA5...; dcache_resp=0 throughout; i_grant_count=1.
- After reset, reqI (16'h0100) and D-cache write (16'h0200, wdata 128'h1234...) both asserted, RR_ENABLE=1:
  - D granted first: arb_write=1, arb_addr=16'h0200.
  - After resp: one IDLE cycle, then I granted with arb_addr=16'h0100.
- RR_ENABLE=0, both requesters continuously re-requesting for 5 transactions -> all 5 grants to D; i_grant_count=0, d_grant_count=5.
- reset asserted mid-SERVE_D (cycle 2, before resp) -> next cycle state IDLE, arb_write=0, counters=0; a later reqI is served normally.
- CNT_WIDTH=2, 5 I-cache transactions -> i_grant_count reads 1,2,3,3,3.
- D-cache drops dcache_read in SERVE_D before resp -> arb_read=0 the same cycle, state IDLE next cycle, assertion fires.
